// File: rtl/tnoc_packet_packer_if.sv
// Packet-side (header/payload) and flit-side signals of the packet packer.
// The slave modport is the packer's own view; master is the view of whatever drives it.
interface tnoc_packet_packer_if #(
  parameter int FLIT_DATA_WIDTH      = 72,
  parameter int DATA_WIDTH           = 64,
  parameter int REQUEST_HEADER_FLITS = 2
);
  logic                                           header_valid;
  logic                                           header_ready;
  logic [REQUEST_HEADER_FLITS*FLIT_DATA_WIDTH-1:0] header_data;
  logic                                           payload_valid;
  logic                                           payload_ready;
  logic                                           payload_last;
  logic [DATA_WIDTH-1:0]                          payload_data;
  logic [DATA_WIDTH/8-1:0]                        payload_byte_enable;
  logic                                           flit_valid;
  logic                                           flit_ready;
  logic                                           flit_type;
  logic                                           flit_head;
  logic                                           flit_tail;
  logic [FLIT_DATA_WIDTH-1:0]                     flit_data;

  modport master (
    output header_valid, header_data,
    output payload_valid, payload_last, payload_data, payload_byte_enable,
    output flit_ready,
    input  header_ready, payload_ready,
    input  flit_valid, flit_type, flit_head, flit_tail, flit_data
  );

  modport slave (
    input  header_valid, header_data,
    input  payload_valid, payload_last, payload_data, payload_byte_enable,
    input  flit_ready,
    output header_ready, payload_ready,
    output flit_valid, flit_type, flit_head, flit_tail, flit_data
  );
endinterface

// File: rtl/tnoc_packet_packer.sv
// Turns one packet (multi-flit header plus optional payload beats) into a registered
// flit stream: header flits first, then one flit per payload beat.
module tnoc_packet_packer #(
  parameter int FLIT_DATA_WIDTH       = 72,
  parameter int DATA_WIDTH            = 64,
  parameter int REQUEST_HEADER_FLITS  = 2,
  parameter int RESPONSE_HEADER_FLITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  tnoc_packet_packer_if.slave  bus,
  output logic [1:0]           state_o
);

  localparam int CNT_W = $clog2(REQUEST_HEADER_FLITS) + 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Valid never waits for ready; the flit outputs hold while flit_valid && !flit_ready.
  logic [1:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       flit_valid_q, flit_valid_d;
  logic                       flit_type_q, flit_type_d;
  logic                       flit_head_q, flit_head_d;
  logic                       flit_tail_q, flit_tail_d;
  logic [FLIT_DATA_WIDTH-1:0] flit_data_q, flit_data_d;

  logic                       load_en;
  logic                       is_request;
  logic                       has_payload;
  logic [CNT_W-1:0]           last_hdr_idx;
  int unsigned                hdr_base;
  logic [FLIT_DATA_WIDTH-1:0] payload_flit;
  logic                       header_ready;
  logic                       payload_ready;

  assign load_en      = !flit_valid_q || bus.flit_ready;
  assign is_request   = bus.header_data[7];
  assign has_payload  = bus.header_data[6];
  assign last_hdr_idx = is_request ? CNT_W'(REQUEST_HEADER_FLITS - 1)
                                   : CNT_W'(RESPONSE_HEADER_FLITS - 1);
  assign hdr_base     = int'(cnt_q) * FLIT_DATA_WIDTH;

  always_comb begin
    payload_flit                         = '0;
    payload_flit[DATA_WIDTH-1:0]         = bus.payload_data;
    payload_flit[DATA_WIDTH +: BE_W]     = bus.payload_byte_enable;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flit_valid_d  = flit_valid_q && !bus.flit_ready;
    flit_type_d   = flit_type_q;
    flit_head_d   = flit_head_q;
    flit_tail_d   = flit_tail_q;
    flit_data_d   = flit_data_q;
    header_ready  = 1'b0;
    payload_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.header_valid && load_en) begin
          flit_valid_d = 1'b1;
          flit_type_d  = 1'b0;
          flit_head_d  = 1'b1;
          flit_data_d  = bus.header_data[FLIT_DATA_WIDTH-1:0];
          if (last_hdr_idx == '0) begin
            header_ready = 1'b1;
            flit_tail_d  = !has_payload;
            state_d      = has_payload ? ST_PAYLOAD : ST_IDLE;
          end else begin
            flit_tail_d  = 1'b0;
            cnt_d        = CNT_W'(1);
            state_d      = ST_HEADER;
          end
        end
      end

      ST_HEADER: begin
        if (load_en) begin
          flit_valid_d = 1'b1;
          flit_type_d  = 1'b0;
          flit_head_d  = 1'b0;
          flit_data_d  = bus.header_data[hdr_base +: FLIT_DATA_WIDTH];
          if (cnt_q == last_hdr_idx) begin
            header_ready = 1'b1;
            cnt_d        = '0;
            flit_tail_d  = !has_payload;
            state_d      = has_payload ? ST_PAYLOAD : ST_IDLE;
          end else begin
            flit_tail_d  = 1'b0;
            cnt_d        = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PAYLOAD: begin
        payload_ready = load_en;
        if (bus.payload_valid && load_en) begin
          flit_valid_d = 1'b1;
          flit_type_d  = 1'b1;
          flit_head_d  = 1'b0;
          flit_tail_d  = bus.payload_last;
          flit_data_d  = payload_flit;
          if (bus.payload_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // No upstream handshake may complete while the block is being reset.
    if (rst) begin
      header_ready  = 1'b0;
      payload_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flit_valid_q <= 1'b0;
      flit_type_q  <= 1'b0;
      flit_head_q  <= 1'b0;
      flit_tail_q  <= 1'b0;
      flit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flit_valid_q <= flit_valid_d;
      flit_type_q  <= flit_type_d;
      flit_head_q  <= flit_head_d;
      flit_tail_q  <= flit_tail_d;
      flit_data_q  <= flit_data_d;
    end
  end

  assign bus.header_ready  = header_ready;
  assign bus.payload_ready = payload_ready;
  assign bus.flit_valid    = flit_valid_q;
  assign bus.flit_type     = flit_type_q;
  assign bus.flit_head     = flit_head_q;
  assign bus.flit_tail     = flit_tail_q;
  assign bus.flit_data     = flit_data_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_tnoc_packet_packer.sv
// Bench for tnoc_packet_packer: packets are described at packet level, a reference model
// expands them into the expected flit list, and a monitor scores every accepted flit.
module tb_tnoc_packet_packer;

  localparam int F   = 72;
  localparam int D   = 64;
  localparam int BE  = D / 8;
  localparam int REQ = 2;
  localparam int RSP = 1;
  localparam int HW  = REQ * F;
  localparam int EW  = F + 3;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         checks;
  int         errors;
  int         ready_mode;
  int         pat;

  logic [EW-1:0] exp_q[$];
  logic [D-1:0]  beat_data_q[$];
  logic [BE-1:0] beat_be_q[$];
  logic          beat_last_q[$];

  logic          prev_stall;
  logic [EW-1:0] prev_snap;

  tnoc_packet_packer_if #(.FLIT_DATA_WIDTH(F), .DATA_WIDTH(D), .REQUEST_HEADER_FLITS(REQ)) bus ();

  tnoc_packet_packer #(
    .FLIT_DATA_WIDTH(F), .DATA_WIDTH(D),
    .REQUEST_HEADER_FLITS(REQ), .RESPONSE_HEADER_FLITS(RSP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Downstream ready: 0 = always, 1 = random, 2 = pattern 1,0,0,1,..., other = held low
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.flit_ready = 1'b1;
      1:       bus.flit_ready = 1'($urandom_range(0, 1));
      2:       bus.flit_ready = ((pat % 3) == 0);
      default: bus.flit_ready = 1'b0;
    endcase
    pat = pat + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    got = {bus.flit_type, bus.flit_head, bus.flit_tail, bus.flit_data};
    if (!rst) begin
      if (prev_stall) begin
        checks = checks + 1;
        if (!bus.flit_valid || got !== prev_snap) begin
          errors = errors + 1;
          $display("FAIL stall_hold: got valid=%b flit=%h, required valid=1 flit=%h", bus.flit_valid, got, prev_snap);
        end
      end
      if (bus.flit_valid && !bus.flit_ready) begin
        checks = checks + 1;
        if (bus.header_ready !== 1'b0 || bus.payload_ready !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL stall_ready: got header_ready=%b payload_ready=%b, required 0/0", bus.header_ready, bus.payload_ready);
        end
      end
      if (bus.flit_valid && bus.flit_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_flit: got flit=%h, required no flit", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL flit: got {type,head,tail,data}=%h, required %h", got, exp);
          end
        end
      end
      prev_stall = bus.flit_valid && !bus.flit_ready;
      prev_snap  = got;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // A packet of type t is N header slices (N from bit7) followed, when bit6 is set,
  // by one flit per payload beat carrying {byte enables, data}.
  task automatic model_packet(input logic [HW-1:0] hd);
    int n;
    logic [F-1:0] pay;
    n = hd[7] ? REQ : RSP;
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b0, (i == 0), (i == n - 1) && !hd[6], hd[i*F +: F]});
    if (hd[6]) begin
      for (int j = 0; j < beat_data_q.size(); j++) begin
        pay = '0;
        pay[D-1:0]   = beat_data_q[j];
        pay[D +: BE] = beat_be_q[j];
        exp_q.push_back({1'b1, 1'b0, beat_last_q[j], pay});
      end
    end
  endtask

  function automatic logic [HW-1:0] rand_hdr(input logic [7:0] ptype);
    logic [159:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    w[7:0] = ptype;
    return w[HW-1:0];
  endfunction

  task automatic make_beats(input int nb);
    for (int i = 0; i < nb; i++) begin
      beat_data_q.push_back({$urandom(), $urandom()});
      beat_be_q.push_back(8'($urandom_range(0, 255)));
      beat_last_q.push_back(i == nb - 1);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_header(input logic [HW-1:0] hd);
    int n;
    bus.header_valid = 1'b1;
    bus.header_data  = hd;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.header_ready) break;
      n++;
      if (n > 300) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL header_timeout: got no header_ready in %0d cycles, required one", n);
        break;
      end
    end
    @(posedge clk); #1;
    bus.header_valid = 1'b0;
  endtask

  task automatic drive_payload();
    int n;
    while (beat_data_q.size() > 0) begin
      bus.payload_valid       = 1'b1;
      bus.payload_data        = beat_data_q[0];
      bus.payload_byte_enable = beat_be_q[0];
      bus.payload_last        = beat_last_q[0];
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.payload_ready) break;
        n++;
        if (n > 300) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL payload_timeout: got no payload_ready in %0d cycles, required one", n);
          break;
        end
      end
      @(posedge clk); #1;
      void'(beat_data_q.pop_front());
      void'(beat_be_q.pop_front());
      void'(beat_last_q.pop_front());
    end
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_drain: got %0d flits still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_ready_mode(input int m);
    @(negedge clk);
    ready_mode = m;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    bus.header_valid  = 1'b1;
    bus.header_data   = rand_hdr(8'h00);
    bus.payload_valid = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (bus.flit_valid !== 1'b0 || bus.flit_type !== 1'b0 || bus.flit_head !== 1'b0 ||
        bus.flit_tail !== 1'b0 || bus.flit_data !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_flit: got v/t/h/t=%b%b%b%b data=%h, required 0000 data=0",
               bus.flit_valid, bus.flit_type, bus.flit_head, bus.flit_tail, bus.flit_data);
    end
    checks = checks + 1;
    if (bus.header_ready !== 1'b0 || bus.payload_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_ready: got header_ready=%b payload_ready=%b, required 0/0", bus.header_ready, bus.payload_ready);
    end
    checks = checks + 1;
    if (state !== 2'd0) begin
      errors = errors + 1;
      $display("FAIL reset_state: got %0d, required 0 (IDLE)", state);
    end
    @(posedge clk); #1;
    bus.header_valid  = 1'b0;
    bus.payload_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_response_no_payload();
    logic [HW-1:0] hd;
    set_ready_mode(0);
    hd = rand_hdr(8'h00);
    model_packet(hd);
    drive_header(hd);
    @(negedge clk);
    checks = checks + 1;
    if (bus.flit_valid !== 1'b1 || bus.flit_head !== 1'b1 || bus.flit_tail !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL resp_latency: got valid/head/tail=%b%b%b one cycle after header_ready, required 111",
               bus.flit_valid, bus.flit_head, bus.flit_tail);
    end
    wait_drain("resp");
  endtask

  task automatic test_request_payload();
    logic [HW-1:0] hd;
    set_ready_mode(0);
    hd = rand_hdr(8'hC0);
    for (int i = 1; i <= 4; i++) begin
      beat_data_q.push_back(64'(i));
      beat_be_q.push_back(8'hFF);
      beat_last_q.push_back(i == 4);
    end
    model_packet(hd);
    fork
      drive_header(hd);
      drive_payload();
    join
    wait_drain("req4");
  endtask

  task automatic test_back_pressure();
    logic [HW-1:0] hd;
    set_ready_mode(2);
    hd = rand_hdr(8'hC0);
    make_beats(2);
    model_packet(hd);
    fork
      drive_header(hd);
      drive_payload();
    join
    wait_drain("bp");
  endtask

  task automatic test_back_to_back();
    logic [HW-1:0] hd0;
    logic [HW-1:0] hd1;
    int n;
    set_ready_mode(0);
    hd0 = rand_hdr(8'h00);
    hd1 = rand_hdr(8'h80);
    model_packet(hd0);
    model_packet(hd1);
    fork
      begin
        drive_header(hd0);
        drive_header(hd1);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.flit_valid && n < 50);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          checks = checks + 1;
          if (bus.flit_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL b2b_contiguous: got flit_valid=%b at flit %0d, required 1", bus.flit_valid, k + 2);
          end
        end
      end
    join
    wait_drain("b2b");
  endtask

  task automatic test_early_payload();
    logic [HW-1:0] hd;
    int n;
    logic seen;
    set_ready_mode(0);
    hd = rand_hdr(8'hC0);
    make_beats(2);
    model_packet(hd);
    fork
      drive_header(hd);
      drive_payload();
      begin
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
          @(negedge clk);
          checks = checks + 1;
          if (bus.payload_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL early_payload_ready: got payload_ready=%b before headers done, required 0", bus.payload_ready);
          end
          if (bus.header_ready) seen = 1'b1;
          n++;
        end
      end
    join
    wait_drain("early");
  endtask

  task automatic test_reset_mid_packet();
    logic [HW-1:0] hd;
    int n;
    set_ready_mode(0);
    hd = rand_hdr(8'hC0);
    exp_q.push_back({1'b0, 1'b1, 1'b0, hd[F-1:0]});
    bus.header_valid = 1'b1;
    bus.header_data  = hd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.flit_valid && bus.flit_ready) && n < 50);
    ready_mode = 3;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.header_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (bus.flit_valid !== 1'b0 || state !== 2'd0 || bus.flit_data !== '0 || bus.flit_head !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mid_reset: got valid=%b state=%0d head=%b data=%h, required 0/0/0/0",
               bus.flit_valid, state, bus.flit_head, bus.flit_data);
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL mid_reset_h0: got %0d unaccepted flits, required H0 accepted", exp_q.size());
      exp_q.delete();
    end
    ready_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    hd = rand_hdr(8'h00);
    model_packet(hd);
    drive_header(hd);
    wait_drain("post_reset");
  endtask

  task automatic test_random();
    logic [HW-1:0] hd;
    logic [7:0]    pt;
    for (int p = 0; p < 25; p++) begin
      set_ready_mode($urandom_range(0, 1));
      pt = 8'($urandom_range(0, 255));
      hd = rand_hdr(pt);
      if (pt[6]) make_beats($urandom_range(1, 4));
      model_packet(hd);
      fork
        drive_header(hd);
        drive_payload();
      join
      wait_drain("random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ready_mode = 0;
    pat = 0;
    prev_stall = 1'b0;
    prev_snap = '0;
    rst = 1'b1;
    bus.header_valid        = 1'b0;
    bus.header_data         = '0;
    bus.payload_valid       = 1'b0;
    bus.payload_last        = 1'b0;
    bus.payload_data        = '0;
    bus.payload_byte_enable = '0;
    bus.flit_ready          = 1'b0;

    test_reset();
    test_response_no_payload();
    test_request_payload();
    test_back_pressure();
    test_back_to_back();
    test_early_payload();
    test_reset_mid_packet();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
